uart_tx_stim: RTL
=================

Name: uart_tx_stim

Overview:
Parametrised, synthesizable UART transmit driver with a byte FIFO. It generalises the fixed 8N1 byte-writer task used on the tt_um_femto RXD pin.
- Serves both as a bench stimulus source and as an on-chip debug TX.
- Bytes are pushed through a valid/ready port, then serialised with configurable framing, start-bit extension and inter-frame gap.
- txd drives tt_um_femto ui_in RXD, or the uo_out TXD slot when used on-chip.

Parameters:
CLKS_PER_BIT, 217, clocks per bit (25 MHz / 115200); legal range 4..65535
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
START_EXTRA, 0, extra clocks appended to the start bit, 0..65535
GAP_CLKS, 0, idle-high clocks inserted after stop bits before the next start bit
DEPTH, 4, FIFO depth in frames, power of two, >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_data  in  DATA_BITS  byte to send
in_valid  in  1  in_data valid
in_ready  out  1  FIFO not full; a push occurs when in_valid && in_ready at a clk edge
txd  out  1  serial output, idle high
busy  out  1  frame in progress, or FIFO not empty
level  out  $clog2(DEPTH)+1  FIFO occupancy
frame_done  out  1  one-cycle pulse in the last clock of the final stop bit (or the last gap clock if GAP_CLKS > 0)

Behaviour:
- Reset (async assert, sync release): txd=1, in_ready=1, busy=0, level=0, frame_done=0, FIFO pointers=0, FSM=IDLE. Reset mid-frame aborts the frame immediately; txd goes high combinationally-free from a flop with async set.
- FIFO: circular buffer, wr/rd pointers with wrap at DEPTH, extra bit for full/empty.
  - in_ready = !full; no bypass, so a push on a full cycle is refused even if a pop happens that cycle.
  - Simultaneous push and pop: level unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP, GAP.
  - IDLE: if FIFO not empty, pop into shift reg, go to START next clock. txd goes low on that same edge (1-clock latency from push into an empty FIFO to the start-bit edge).
  - START: txd=0 for CLKS_PER_BIT+START_EXTRA clocks.
  - DATA: DATA_BITS bits, LSB first, CLKS_PER_BIT each; bit counter $clog2(DATA_BITS+1) wide.
  - PAR: entered only if PARITY != 0. Value is XOR of the data (even) or its inverse (odd); duration CLKS_PER_BIT.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT.
  - GAP: txd=1 for GAP_CLKS, skipped when 0.
  - After the last period: if the FIFO is non-empty, pop and enter START directly (back-to-back frames, no idle clock); else go to IDLE.
- Baud counter: 16 bits, loaded with the period minus 1, counts down; the state advances at 0. Start-bit period = CLKS_PER_BIT+START_EXTRA, so the counter widens to 17 bits when the sum exceeds 65535.
- busy = (state != IDLE) || !empty.
- Elaboration: illegal parameters (PARITY > 2, STOP_BITS outside 1..2, DEPTH not a power of two) trigger $error in an initial block guarded by ifndef SYNTHESIS.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE..GAP)
  - parity encoding constants PAR_NONE/PAR_EVEN/PAR_ODD
  - function clks_per_bit(clk_hz, baud) with rounding
- One sub-module, sync_fifo (WIDTH, DEPTH), reused later by the UART RX monitor.
- The FSM and shifter stay in uart_tx_stim.

Test Plan:
1. Defaults, push 0x38 once. Required response:
   - txd low 217 clocks (start)
   - then 0,0,0,1,1,1,0,0 at 217 clocks each
   - then high 217 clocks
   - frame_done pulses at clock 2170 after the start edge; busy falls on the next clock.
2. Push 0x38, 0x2A, 0x39 back to back. Required response:
   - level peaks at 2 (one byte popped immediately)
   - frames contiguous with no extra idle clocks: 3 start edges exactly 2170 clocks apart
   - 3 frame_done pulses.
3. PARITY=1, STOP_BITS=2, push 0x37 (five ones). Parity bit = 1; total frame length 12*217 = 2604 clocks. With PARITY=2 the parity bit = 0.
4. START_EXTRA=25, GAP_CLKS=100, push two bytes. Required response:
   - start bit 242 clocks
   - start-to-start spacing 2170+25+100 = 2295 clocks.
5. DEPTH=4, hold in_valid with pushes 1..6 while txd is busy. Required response:
   - in_ready drops when level reaches 4; no byte is lost or duplicated
   - a decoding monitor sees 1..6 in order.
6. Assert rst_n low at mid data bit 3. Required response:
   - txd=1, level=0, busy=0 within the reset cycle, no frame_done
   - after release, a new push transmits a correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and a
// baud-divisor helper used to size CLKS_PER_BIT from clock and baud rates.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        GAP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Rounds to the nearest whole clock count per bit.
    function automatic longint unsigned clks_per_bit(input longint unsigned clk_hz,
                                                     input longint unsigned baud);
        return (clk_hz + baud / 64'd2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_stim_sync_fifo.sv
// Synchronous circular FIFO with an extra pointer bit for full/empty.
// Read data is the head entry, valid whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A push while full is refused even if a pop happens in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_stim.sv
// UART transmit driver: byte FIFO feeding a framing FSM with configurable
// parity, stop bits, start-bit extension and inter-frame idle gap.
module uart_tx_stim
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int START_EXTRA  = 0,
    parameter int GAP_CLKS     = 0,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_BITS-1:0]     in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     txd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_done
);

    localparam int START_LEN = CLKS_PER_BIT + START_EXTRA;
    localparam int MAX_LEN   = (START_LEN > GAP_CLKS) ? START_LEN : GAP_CLKS;
    localparam int CNT_W     = (MAX_LEN > 65535) ? 17 : 16;
    localparam int BC_W      = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] START_M1 = CNT_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0] CPB_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_BITS - 1);

`ifndef SYNTHESIS
    initial begin
        if (PARITY < 0 || PARITY > 2)
            $error("uart_tx_stim: PARITY must be 0, 1 or 2");
        if (STOP_BITS < 1 || STOP_BITS > 2)
            $error("uart_tx_stim: STOP_BITS must be 1 or 2");
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
            $error("uart_tx_stim: DEPTH must be a power of two >= 2");
    end
`endif

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BC_W-1:0]        bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic                   par_q, par_d;
    logic                   txd_q, txd_d;

    logic [DATA_BITS-1:0]   fifo_rd;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   period_end;
    logic                   last_stop;
    logic                   frame_end;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // txd is a flop with async set so reset forces the line idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        sh_d    = sh_q;
        par_d   = par_q;
        txd_d   = txd_q;
        if (state_q != IDLE && !period_end) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    cnt_d   = CPB_M1;
                    bit_d   = '0;
                    txd_d   = sh_q[0];
                end
                DATA: begin
                    cnt_d = CPB_M1;
                    if (bit_q == LAST_BIT) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            stop_d  = 1'b0;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                    end
                end
                PAR: begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                    cnt_d   = CPB_M1;
                    txd_d   = 1'b1;
                end
                STOP: begin
                    if (!last_stop) begin
                        stop_d = 1'b1;
                        cnt_d  = CPB_M1;
                    end else if (GAP_CLKS != 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_M1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                GAP:     state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
        // A pop starts the next frame directly, overriding the idle return.
        if (pop) begin
            state_d = START;
            cnt_d   = START_M1;
            sh_d    = fifo_rd;
            par_d   = (^fifo_rd) ^ (PARITY == PAR_ODD);
            txd_d   = 1'b0;
        end
    end

    always_comb begin
        period_end = (cnt_q == '0);
        last_stop  = (STOP_BITS == 1) || stop_q;
        frame_end  = period_end &&
                     ((state_q == STOP && last_stop && GAP_CLKS == 0) || state_q == GAP);
        pop        = !fifo_empty && (state_q == IDLE || frame_end);
        frame_done = frame_end;
        busy       = (state_q != IDLE) || !fifo_empty;
        in_ready   = !fifo_full;
        txd        = txd_q;
    end

endmodule
